// File: rtl/crossover_pkg.sv
// Shared constants and the circular mask builder for the GA crossover operator.
package crossover_pkg;

    localparam logic [31:0] LFSR_SEED = 32'h0000_0001;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // Upper bound on chromosome width supported by rotl_mask.
    localparam int unsigned MASK_MAX_W = 256;
    localparam int unsigned MASK_IDX_W = $clog2(MASK_MAX_W);

    // Rotates the low w bits of base left by rot (rot < w), circular within w bits.
    function automatic logic [MASK_MAX_W-1:0] rotl_mask(
        input logic [MASK_MAX_W-1:0] base,
        input int unsigned           rot,
        input int unsigned           w
    );
        logic [MASK_MAX_W-1:0] m;
        int unsigned           idx;
        m = '0;
        for (int unsigned i = 0; i < MASK_MAX_W; i++) begin
            if (i < w) begin
                idx = i + rot;
                if (idx >= w) idx = idx - w;
                m[idx[MASK_IDX_W-1:0]] = base[i];
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/crossover_lfsr.sv
// Right-shifting Galois LFSR; advances on each enabled edge, reseeds on reset.
module crossover_lfsr
    import crossover_pkg::*;
#(
    parameter int                   LfsrWidth = 32,
    parameter logic [LfsrWidth-1:0] Seed      = LfsrWidth'(LFSR_SEED),
    parameter logic [LfsrWidth-1:0] Taps      = LfsrWidth'(LFSR_TAPS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    output logic [LfsrWidth-1:0] state
);

    logic [LfsrWidth-1:0] lfsr_q, lfsr_d;

    always_comb begin
        // NOTE: default first so every path assigns lfsr_d and no latch is inferred.
        lfsr_d = lfsr_q;
        if (ce) lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? Taps : '0);
    end

    // NOTE: state registers use non-blocking assignment so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr_q <= Seed;
        else      lfsr_q <= lfsr_d;
    end

    assign state = lfsr_q;

endmodule

// File: rtl/crossover.sv
// GA crossover: mixes dad/mom through a rotated contiguous mask driven by an LFSR.
// Optional CROSSOVER_MASK_OUT_EN exposes the registered mask on mask_o.
module crossover
    import crossover_pkg::*;
#(
    parameter int InidividualWidth    = 32,
    parameter int RotationIndexWidth  = $clog2(InidividualWidth),
    parameter int CrossMaskIndexWidth = $clog2(InidividualWidth),
    parameter int LfsrWidth           = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ce,
    input  logic [InidividualWidth-1:0] dad,
    input  logic [InidividualWidth-1:0] mom,
`ifdef CROSSOVER_MASK_OUT_EN
    output logic [InidividualWidth-1:0] mask_o,
`endif
    output logic [InidividualWidth-1:0] son,
    output logic [InidividualWidth-1:0] daughter
);

    localparam int unsigned WU = InidividualWidth;

    logic [LfsrWidth-1:0]           lfsr_state;
    logic [RotationIndexWidth-1:0]  rot;
    logic [CrossMaskIndexWidth-1:0] cut;
    int unsigned                    rot_eff, cut_eff;
    logic [InidividualWidth-1:0]    one, base, mask;
    logic [MASK_MAX_W-1:0]          mask_full;
    logic [InidividualWidth-1:0]    son_q, son_d, daughter_q, daughter_d;

    crossover_lfsr #(
        .LfsrWidth (LfsrWidth),
        .Seed      (LfsrWidth'(LFSR_SEED)),
        .Taps      (LfsrWidth'(LFSR_TAPS))
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .ce    (ce),
        .state (lfsr_state)
    );

    assign rot = lfsr_state[RotationIndexWidth-1:0];
    assign cut = lfsr_state[RotationIndexWidth +: CrossMaskIndexWidth];

    // rot spans fewer than 2W codes, so one conditional subtract implements mod W.
    always_comb begin
        rot_eff   = (32'(rot) >= WU) ? 32'(rot) - WU : 32'(rot);
        cut_eff   = (32'(cut) > WU - 1) ? WU - 1 : 32'(cut);
        one       = InidividualWidth'(1);
        base      = (one << cut_eff) - one;
        mask_full = rotl_mask(MASK_MAX_W'(base), rot_eff, WU);
        mask      = mask_full[InidividualWidth-1:0];
    end

    always_comb begin
        son_d      = son_q;
        daughter_d = daughter_q;
        if (ce) begin
            son_d      = (dad & mask) | (mom & ~mask);
            daughter_d = (mom & mask) | (dad & ~mask);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            son_q      <= '0;
            daughter_q <= '0;
        end else begin
            son_q      <= son_d;
            daughter_q <= daughter_d;
        end
    end

    assign son      = son_q;
    assign daughter = daughter_q;

`ifdef CROSSOVER_MASK_OUT_EN
    logic [InidividualWidth-1:0] mask_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    mask_q <= '0;
        else if (ce) mask_q <= mask;
    end

    assign mask_o = mask_q;
`endif

endmodule

// File: tb/tb_crossover.sv
// Self-checking bench for crossover: random parents against a behavioural LFSR/mask model.
`timescale 1ns/100ps
module tb_crossover;

    localparam logic [31:0] TAPS = 32'h8020_0003;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce  = 1'b0;
    logic [31:0] dad = '0;
    logic [31:0] mom = '0;
    logic [31:0] son, daughter;
`ifdef CROSSOVER_MASK_OUT_EN
    logic [31:0] mask_o;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] m_lfsr = 32'h1;
    logic [31:0] exp_son = '0, exp_dau = '0, exp_mask = '0;
    int unsigned exp_cut = 0;

    always #1 clk = ~clk;

    crossover dut (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .dad      (dad),
        .mom      (mom),
`ifdef CROSSOVER_MASK_OUT_EN
        .mask_o   (mask_o),
`endif
        .son      (son),
        .daughter (daughter)
    );

    function automatic int unsigned cut_of(input logic [31:0] l);
        int unsigned c;
        c = (l >> 5) & 32'h1F;
        return (c > 31) ? 31 : c;
    endfunction

    // base = cut low ones, rotated left by rot within 32 bits
    function automatic logic [31:0] ref_mask(input logic [31:0] l);
        int unsigned  rot;
        longint unsigned base, r;
        rot  = (l & 32'h1F) % 32;
        base = (64'd1 << cut_of(l)) - 64'd1;
        r    = ((base << rot) | (base >> (32 - rot))) & 64'hFFFF_FFFF;
        return r[31:0];
    endfunction

    function automatic int unsigned popcnt(input logic [31:0] v);
        int unsigned n = 0;
        for (int i = 0; i < 32; i++) n += v[i];
        return n;
    endfunction

    // Drive at a negedge, let one posedge pass, update the model, return at the next negedge.
    task automatic cycle(input logic [31:0] d, input logic [31:0] m, input logic c);
        dad = d;
        mom = m;
        ce  = c;
        @(posedge clk);
        if (c && rst) begin
            exp_cut  = cut_of(m_lfsr);
            exp_mask = ref_mask(m_lfsr);
            exp_son  = (d & exp_mask) | (m & ~exp_mask);
            exp_dau  = (m & exp_mask) | (d & ~exp_mask);
            m_lfsr   = (m_lfsr >> 1) ^ (m_lfsr[0] ? TAPS : 32'h0);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cycle($urandom, $urandom, 1'b1);
        checks++;
        if (son !== 32'h0) begin errors++; $display("FAIL reset_son got %h exp %h", son, 32'h0); end
        checks++;
        if (daughter !== 32'h0) begin errors++; $display("FAIL reset_daughter got %h exp %h", daughter, 32'h0); end
`ifdef CROSSOVER_MASK_OUT_EN
        checks++;
        if (mask_o !== 32'h0) begin errors++; $display("FAIL reset_mask got %h exp %h", mask_o, 32'h0); end
`endif
        rst    = 1'b1;
        m_lfsr = 32'h1;
        cycle(32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        checks++;
        if (son !== 32'h9ABC_DEF0) begin errors++; $display("FAIL first_son got %h exp %h", son, 32'h9ABC_DEF0); end
        checks++;
        if (daughter !== 32'h1234_5678) begin errors++; $display("FAIL first_daughter got %h exp %h", daughter, 32'h1234_5678); end
    endtask

    task automatic test_equal_parents();
        for (int i = 0; i < 20; i++) begin
            cycle(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
            checks++;
            if (son !== 32'hDEAD_BEEF) begin errors++; $display("FAIL equal_son[%0d] got %h exp %h", i, son, 32'hDEAD_BEEF); end
            checks++;
            if (daughter !== 32'hDEAD_BEEF) begin errors++; $display("FAIL equal_daughter[%0d] got %h exp %h", i, daughter, 32'hDEAD_BEEF); end
        end
    endtask

    task automatic test_mask_exposure();
        for (int i = 0; i < 100; i++) begin
            cycle(32'hFFFF_FFFF, 32'h0, 1'b1);
            checks++;
            if (son !== exp_mask) begin errors++; $display("FAIL mask_son[%0d] got %h exp %h", i, son, exp_mask); end
            checks++;
            if (daughter !== ~exp_mask) begin errors++; $display("FAIL mask_daughter[%0d] got %h exp %h", i, daughter, ~exp_mask); end
            checks++;
            if (popcnt(son) != exp_cut) begin errors++; $display("FAIL mask_popcount[%0d] got %0d exp %0d", i, popcnt(son), exp_cut); end
        end
    endtask

    task automatic test_random();
        logic [31:0] d, m;
        for (int i = 0; i < 100; i++) begin
            d = $urandom;
            m = $urandom;
            cycle(d, m, 1'b1);
            checks++;
            if (son !== exp_son) begin errors++; $display("FAIL rand_son[%0d] got %h exp %h", i, son, exp_son); end
            checks++;
            if (daughter !== exp_dau) begin errors++; $display("FAIL rand_daughter[%0d] got %h exp %h", i, daughter, exp_dau); end
            checks++;
            if ((son ^ daughter) !== (d ^ m)) begin errors++; $display("FAIL rand_xor[%0d] got %h exp %h", i, son ^ daughter, d ^ m); end
`ifdef CROSSOVER_MASK_OUT_EN
            checks++;
            if (mask_o !== exp_mask) begin errors++; $display("FAIL rand_mask[%0d] got %h exp %h", i, mask_o, exp_mask); end
`endif
        end
    endtask

    task automatic test_enable_hold();
        for (int i = 0; i < 5; i++) begin
            cycle($urandom, $urandom, 1'b0);
            checks++;
            if (son !== exp_son) begin errors++; $display("FAIL hold_son[%0d] got %h exp %h", i, son, exp_son); end
            checks++;
            if (daughter !== exp_dau) begin errors++; $display("FAIL hold_daughter[%0d] got %h exp %h", i, daughter, exp_dau); end
`ifdef CROSSOVER_MASK_OUT_EN
            checks++;
            if (mask_o !== exp_mask) begin errors++; $display("FAIL hold_mask[%0d] got %h exp %h", i, mask_o, exp_mask); end
`endif
        end
        // The mask after re-enable exposes whether the LFSR held.
        for (int i = 0; i < 3; i++) begin
            cycle(32'hFFFF_FFFF, 32'h0, 1'b1);
            checks++;
            if (son !== exp_mask) begin errors++; $display("FAIL resume_mask[%0d] got %h exp %h", i, son, exp_mask); end
        end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] first_run [37];
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst    = 1'b1;
        m_lfsr = 32'h1;
        for (int i = 0; i < 37; i++) begin
            cycle(32'hFFFF_FFFF, 32'h0, 1'b1);
            first_run[i] = exp_mask;
            checks++;
            if (son !== exp_mask) begin errors++; $display("FAIL run1_son[%0d] got %h exp %h", i, son, exp_mask); end
        end
        #0.5 rst = 1'b0;
        #0.2;
        checks++;
        if (son !== 32'h0) begin errors++; $display("FAIL midreset_son got %h exp %h", son, 32'h0); end
        checks++;
        if (daughter !== 32'h0) begin errors++; $display("FAIL midreset_daughter got %h exp %h", daughter, 32'h0); end
        @(negedge clk);
        rst    = 1'b1;
        m_lfsr = 32'h1;
        for (int i = 0; i < 37; i++) begin
            cycle(32'hFFFF_FFFF, 32'h0, 1'b1);
            checks++;
            if (son !== first_run[i]) begin errors++; $display("FAIL run2_son[%0d] got %h exp %h", i, son, first_run[i]); end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_equal_parents();
        test_mask_exposure();
        test_random();
        test_enable_hold();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
